// File: rtl/ingress_dequeue_if.sv
// Port bundle between the VOQ read engine and its neighbours: scheduler, VMU,
// data memory, CMU free list and crossbar.
interface ingress_dequeue_if #(
  parameter int ADDR_W     = 10,
  parameter int DATA_WIDTH = 32,
  parameter int EGRESS_CNT = 4
);
  localparam int SEL_W = (EGRESS_CNT > 1) ? $clog2(EGRESS_CNT) : 1;

  logic                  sched_en;
  logic [SEL_W-1:0]      sched_sel;
  logic                  sched_done;
  logic                  sched_empty;
  logic                  voq_dequeue_en;
  logic [SEL_W-1:0]      voq_dequeue_sel;
  logic [ADDR_W-1:0]     meta_out;
  logic [EGRESS_CNT-1:0] is_empty;
  logic [ADDR_W+2:0]     d_ra;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  free_en;
  logic [ADDR_W-1:0]     free_addr;
  logic [ADDR_W-1:0]     next_free_addr;
  logic [DATA_WIDTH-1:0] packet_out;
  logic                  packet_out_en;
  logic                  packet_out_sop;
  logic                  packet_out_eop;

  modport master (
    input  sched_en, sched_sel, meta_out, is_empty, d_q, next_free_addr,
    output sched_done, sched_empty, voq_dequeue_en, voq_dequeue_sel, d_ra,
           free_en, free_addr, packet_out, packet_out_en, packet_out_sop,
           packet_out_eop
  );

  modport slave (
    output sched_en, sched_sel, meta_out, is_empty, d_q, next_free_addr,
    input  sched_done, sched_empty, voq_dequeue_en, voq_dequeue_sel, d_ra,
           free_en, free_addr, packet_out, packet_out_en, packet_out_sop,
           packet_out_eop
  );
endinterface

// File: rtl/ingress_dequeue.sv
// VOQ read engine: dequeues a packet head on grant, walks its block chain in
// dmem, streams words with sop/eop and frees each block as it is consumed.
//
// state | meaning
// IDLE  | wait for a grant; refuse it with sched_empty if the VOQ is empty
// DEQ   | one-cycle dequeue strobe to the VMU
// LATCH | capture the head block address from meta_out
// READ  | one dmem issue per cycle; header length latched on the 2nd cycle
// DRAIN | last word leaves with eop and sched_done
module ingress_dequeue #(
  parameter int ADDR_W     = 10,
  parameter int DATA_WIDTH = 32,
  parameter int EGRESS_CNT = 4
)(
  input  logic              clk,
  input  logic              reset_n,
  ingress_dequeue_if.master bus
);
  localparam int SEL_W = (EGRESS_CNT > 1) ? $clog2(EGRESS_CNT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEQ   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_cur_blk;
  logic [2:0]        r_offset;
  logic [5:0]        r_issued;
  logic [5:0]        r_len;
  logic              r_out_en;
  logic              r_sop;
  logic              r_eop;
  logic              r_empty;

  logic [5:0]        w_hdr_len;
  logic [5:0]        w_len;
  logic              w_read;
  logic              w_last;
  logic              w_cross;

  // Short headers are padded to 3 words so the length is known before it matters.
  assign w_hdr_len = (bus.d_q[26:21] < 6'd3) ? 6'd3 : bus.d_q[26:21];
  assign w_len     = (r_issued == 6'd1) ? w_hdr_len : r_len;
  assign w_read    = (r_state == S_READ);
  assign w_last    = w_read && (r_issued == (w_len - 6'd1));
  assign w_cross   = w_read && (r_offset == 3'd7) && !w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_cur_blk <= '0;
      r_offset  <= '0;
      r_issued  <= '0;
      r_len     <= '0;
      r_out_en  <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_empty   <= 1'b0;
    end else begin
      r_empty  <= 1'b0;
      r_out_en <= w_read;
      r_sop    <= w_read && (r_issued == 6'd0);
      r_eop    <= w_last;
      case (r_state)
        S_IDLE: begin
          if (bus.sched_en) begin
            if (bus.is_empty[bus.sched_sel]) begin
              r_empty <= 1'b1;
            end else begin
              r_sel   <= bus.sched_sel;
              r_state <= S_DEQ;
            end
          end
        end
        S_DEQ: r_state <= S_LATCH;
        S_LATCH: begin
          r_cur_blk <= bus.meta_out;
          r_offset  <= '0;
          r_issued  <= '0;
          r_state   <= S_READ;
        end
        S_READ: begin
          r_offset <= r_offset + 3'd1;
          r_issued <= r_issued + 6'd1;
          if (r_issued == 6'd1) r_len <= w_hdr_len;
          // Next block comes only from the CMU chain; offset never carries.
          if (w_cross) r_cur_blk <= bus.next_free_addr;
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sched_done      = (r_state == S_DRAIN);
  assign bus.sched_empty     = r_empty;
  assign bus.voq_dequeue_en  = (r_state == S_DEQ);
  assign bus.voq_dequeue_sel = (r_state == S_DEQ) ? r_sel : '0;
  assign bus.d_ra            = w_read ? {r_cur_blk, r_offset} : '0;
  assign bus.free_en         = w_read && ((r_offset == 3'd7) || w_last);
  assign bus.free_addr       = bus.free_en ? r_cur_blk : '0;
  assign bus.packet_out      = r_out_en ? bus.d_q : '0;
  assign bus.packet_out_en   = r_out_en;
  assign bus.packet_out_sop  = r_out_en && r_sop;
  assign bus.packet_out_eop  = r_out_en && r_eop;
endmodule

// File: tb/tb_ingress_dequeue.sv
// Bench for ingress_dequeue: VMU/dmem/CMU models plus a per-cycle expectation
// built from packet length, block chain and grant timing.
module tb_ingress_dequeue;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int EC  = 4;
  localparam int RAW = AW + 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ingress_dequeue_if #(.ADDR_W(AW), .DATA_WIDTH(DW), .EGRESS_CNT(EC)) bus ();

  ingress_dequeue #(.ADDR_W(AW), .DATA_WIDTH(DW), .EGRESS_CNT(EC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  logic [DW-1:0] mem  [0:(1<<RAW)-1];
  logic [AW-1:0] nxt  [0:(1<<AW)-1];
  logic [AW-1:0] head [0:EC-1];
  int n_assert = 0;
  int n_fail   = 0;
  int ch [0:7];

  always @(posedge clk) begin
    bus.d_q <= mem[bus.d_ra];
    if (bus.voq_dequeue_en) bus.meta_out <= head[bus.voq_dequeue_sel];
  end
  assign bus.next_free_addr = nxt[bus.free_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " d_ra"}, {51'd0, bus.d_ra}, 64'd0);
    chk({tag, " free"}, {53'd0, bus.free_en, bus.free_addr}, 64'd0);
    chk({tag, " pkt"}, {29'd0, bus.packet_out_en, bus.packet_out_sop,
                        bus.packet_out_eop, bus.packet_out}, 64'd0);
    chk({tag, " ctrl"}, {59'd0, bus.voq_dequeue_en, bus.voq_dequeue_sel,
                         bus.sched_done, bus.sched_empty}, 64'd0);
  endtask

  task automatic gen_chain(input int nb);
    for (int j = 0; j < nb; j++) begin
      bit dup;
      do begin
        ch[j] = int'($urandom_range(0, (1 << AW) - 1));
        dup = 1'b0;
        for (int m = 0; m < j; m++) if (ch[m] == ch[j]) dup = 1'b1;
      end while (dup);
    end
  endtask

  task automatic load_pkt(input int sel, input int lraw, input int nb);
    logic [DW-1:0] hdr;
    for (int j = 0; j < nb; j++) begin
      for (int w = 0; w < 8; w++) mem[ch[j]*8 + w] = $urandom;
      nxt[ch[j]] = (j + 1 < nb) ? AW'(ch[j+1]) : AW'($urandom);
    end
    hdr = $urandom;
    hdr[26:21] = 6'(lraw);
    mem[ch[0]*8] = hdr;
    head[sel] = AW'(ch[0]);
  endtask

  // Called at the negedge of grant cycle 0; ends at the negedge of cycle L+4.
  task automatic run_pkt(input string tag, input int sel, input int lraw,
                         input int mid_cyc, input int rst_cyc);
    int L;
    int nfree;
    int i;
    logic [EC-1:0] emp;
    logic [RAW-1:0] e_dra;
    logic e_fe, e_pen, e_sop, e_eop, e_done, e_deq;
    logic [AW-1:0] e_fa;
    logic [DW-1:0] e_po;
    logic [1:0] e_dsel;
    string t;
    L = (lraw < 3) ? 3 : lraw;
    nfree = 0;
    emp = EC'($urandom);
    emp[sel] = 1'b0;
    bus.is_empty  = emp;
    bus.sched_sel = 2'(sel);
    bus.sched_en  = 1'b1;
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.sched_en = 1'b0;
      t = $sformatf("%s c%0d", tag, k);
      if (k == rst_cyc) begin
        reset_n = 1'b0;
        #1;
        chk_quiet({t, " rst"});
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      e_dra = '0; e_fe = 1'b0; e_fa = '0;
      e_po = '0; e_pen = 1'b0; e_sop = 1'b0; e_eop = 1'b0;
      if (k >= 3 && k <= L + 2) begin
        i = k - 3;
        e_dra = RAW'(ch[i/8]*8 + i%8);
        if ((i % 8 == 7) || (i == L - 1)) begin
          e_fe = 1'b1;
          e_fa = AW'(ch[i/8]);
        end
      end
      if (k >= 4 && k <= L + 3) begin
        i = k - 4;
        e_pen = 1'b1;
        e_po  = mem[ch[i/8]*8 + i%8];
        e_sop = (i == 0);
        e_eop = (i == L - 1);
      end
      e_done = (k == L + 3);
      e_deq  = (k == 1);
      e_dsel = (k == 1) ? 2'(sel) : 2'd0;
      chk({t, " d_ra"}, {51'd0, bus.d_ra}, {51'd0, e_dra});
      chk({t, " free"}, {53'd0, bus.free_en, bus.free_addr}, {53'd0, e_fe, e_fa});
      chk({t, " pkt"}, {29'd0, bus.packet_out_en, bus.packet_out_sop,
                        bus.packet_out_eop, bus.packet_out},
                       {29'd0, e_pen, e_sop, e_eop, e_po});
      chk({t, " ctrl"}, {59'd0, bus.voq_dequeue_en, bus.voq_dequeue_sel,
                         bus.sched_done, bus.sched_empty},
                        {59'd0, e_deq, e_dsel, e_done, 1'b0});
      if (bus.free_en) nfree++;
      if (k == mid_cyc) begin
        bus.sched_en  = 1'b1;
        bus.sched_sel = 2'($urandom_range(0, EC - 1));
      end
      if (k == mid_cyc + 1) bus.sched_en = 1'b0;
    end
    chk({tag, " nfree"}, 64'(nfree), 64'((L + 7) / 8));
  endtask

  initial begin
    int lraw, L, nb, sel, mid;
    for (int a = 0; a < (1 << RAW); a++) mem[a] = $urandom;
    for (int a = 0; a < (1 << AW); a++) nxt[a] = AW'($urandom);
    for (int a = 0; a < EC; a++) head[a] = '0;
    bus.sched_en  = 1'b0;
    bus.sched_sel = '0;
    bus.is_empty  = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    ch[0] = 5;
    load_pkt(1, 5, 1);
    run_pkt("l5_blk5", 1, 5, -5, -5);

    ch[0] = 3;
    load_pkt(0, 8, 1);
    run_pkt("l8_blk3", 0, 8, -5, -5);

    ch[0] = 7; ch[1] = 2; ch[2] = 9;
    load_pkt(2, 20, 3);
    run_pkt("l20_chain", 2, 20, -5, -5);

    bus.is_empty  = 4'b0100;
    bus.sched_sel = 2'd2;
    bus.sched_en  = 1'b1;
    @(negedge clk);
    bus.sched_en = 1'b0;
    chk("empty c1 ctrl", {59'd0, bus.voq_dequeue_en, bus.voq_dequeue_sel,
                          bus.sched_done, bus.sched_empty}, 64'd1);
    @(negedge clk);
    chk_quiet("empty c2");

    gen_chain(2);
    load_pkt(3, 12, 2);
    run_pkt("mid_grant", 3, 12, 6, -5);

    gen_chain(1);
    load_pkt(0, 0, 1);
    run_pkt("l0", 0, 0, -5, -5);

    gen_chain(2);
    load_pkt(1, 10, 2);
    run_pkt("rst_mid", 1, 10, -5, 7);

    gen_chain(2);
    load_pkt(2, 9, 2);
    run_pkt("after_rst_l9", 2, 9, -5, -5);

    for (int n = 0; n < 30; n++) begin
      lraw = int'($urandom_range(0, 63));
      L    = (lraw < 3) ? 3 : lraw;
      nb   = (L + 7) / 8;
      sel  = int'($urandom_range(0, EC - 1));
      mid  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, L + 3)) : -5;
      gen_chain(nb);
      load_pkt(sel, lraw, nb);
      run_pkt($sformatf("rnd%0d_l%0d", n, L), sel, lraw, mid, -5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
